// File: rtl/hft_pkg.sv
// Shared definitions for the market-data sampling blocks.
package hft_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned BUFFER_SIZE_DEF = 20;
  localparam int unsigned NUM_STOCKS_DEF  = 4;

  typedef enum logic {
    SIDE_BID = 1'b0,
    SIDE_ASK = 1'b1
  } side_t;

endpackage

// File: rtl/window_ptr.sv
// Per-stock circular write pointer and saturating sample count for the window.
module window_ptr #(
  parameter int unsigned BUFFER_SIZE = 20,
  parameter int unsigned PTR_W       = 5,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             advance,
  input  logic             clear,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count
);

  // Clear beats advance; pointer wraps at the last slot, count saturates at the depth.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (advance) begin
      wr_ptr <= (wr_ptr == PTR_W'(BUFFER_SIZE - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (count != CNT_W'(BUFFER_SIZE)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mid_price_sampler.sv
// Tracks top-of-book per stock and emits a sample whenever a valid, uncrossed
// book changes, together with its slot in the per-stock sample window.
module mid_price_sampler
  import hft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned BUFFER_SIZE = BUFFER_SIZE_DEF,
  parameter int unsigned NUM_STOCKS  = NUM_STOCKS_DEF
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset_n,
  input  logic                                        i_upd_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0]               i_upd_stock_id,
  input  logic                                        i_upd_side,
  input  logic [DATA_WIDTH-1:0]                       i_upd_price,
  input  logic                                        i_upd_empty,
  input  logic                                        i_win_clear,
  output logic                                        o_valid,
  output logic [$clog2(NUM_STOCKS)-1:0]               o_stock_id,
  output logic [DATA_WIDTH-1:0]                       o_best_bid,
  output logic [DATA_WIDTH-1:0]                       o_best_ask,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0]   o_write_address,
  output logic                                        o_window_full,
  output logic                                        o_crossed
);

  localparam int unsigned ID_W   = $clog2(NUM_STOCKS);
  localparam int unsigned ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE);
  localparam int unsigned PTR_W  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int unsigned CNT_W  = $clog2(BUFFER_SIZE + 1);

  logic [DATA_WIDTH-1:0] bid_q    [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] ask_q    [NUM_STOCKS];
  logic                  bid_ok_q [NUM_STOCKS];
  logic                  ask_ok_q [NUM_STOCKS];
  logic [PTR_W-1:0]      wr_ptr   [NUM_STOCKS];
  logic [CNT_W-1:0]      count    [NUM_STOCKS];

  side_t                 upd_side;
  logic [DATA_WIDTH-1:0] nxt_bid;
  logic [DATA_WIDTH-1:0] nxt_ask;
  logic                  nxt_bid_ok;
  logic                  nxt_ask_ok;
  logic                  changed;
  logic                  sample_c;
  logic                  crossed_c;
  logic [ADDR_W-1:0]     addr_c;
  logic                  full_c;

  assign upd_side = side_t'(i_upd_side);

  // Post-update view of the addressed stock's book and the sample/cross decision.
  always_comb begin
    nxt_bid    = bid_q[i_upd_stock_id];
    nxt_ask    = ask_q[i_upd_stock_id];
    nxt_bid_ok = bid_ok_q[i_upd_stock_id];
    nxt_ask_ok = ask_ok_q[i_upd_stock_id];
    changed    = 1'b0;
    sample_c   = 1'b0;
    crossed_c  = 1'b0;
    if (i_upd_valid) begin
      if (upd_side == SIDE_BID) begin
        changed    = (i_upd_price != bid_q[i_upd_stock_id]) || !bid_ok_q[i_upd_stock_id];
        nxt_bid_ok = !i_upd_empty;
        if (!i_upd_empty) nxt_bid = i_upd_price;
      end else begin
        changed    = (i_upd_price != ask_q[i_upd_stock_id]) || !ask_ok_q[i_upd_stock_id];
        nxt_ask_ok = !i_upd_empty;
        if (!i_upd_empty) nxt_ask = i_upd_price;
      end
      if (!i_upd_empty && nxt_bid_ok && nxt_ask_ok) begin
        crossed_c = (nxt_bid >= nxt_ask);
        sample_c  = (nxt_bid < nxt_ask) && changed && !i_win_clear;
      end
    end
  end

  // Slot address from the pre-increment pointer; full if this sample fills the window.
  always_comb begin
    addr_c = ADDR_W'(i_upd_stock_id) * ADDR_W'(BUFFER_SIZE) + ADDR_W'(wr_ptr[i_upd_stock_id]);
    full_c = (count[i_upd_stock_id] >= CNT_W'(BUFFER_SIZE - 1));
  end

  // Per-stock book storage; prices are kept even when the update is crossed or cleared.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        bid_q[s]    <= '0;
        ask_q[s]    <= '0;
        bid_ok_q[s] <= 1'b0;
        ask_ok_q[s] <= 1'b0;
      end
    end else if (i_upd_valid) begin
      bid_q[i_upd_stock_id]    <= nxt_bid;
      ask_q[i_upd_stock_id]    <= nxt_ask;
      bid_ok_q[i_upd_stock_id] <= nxt_bid_ok;
      ask_ok_q[i_upd_stock_id] <= nxt_ask_ok;
    end
  end

  // One window pointer per stock.
  for (genvar s = 0; s < NUM_STOCKS; s++) begin : g_win
    window_ptr #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .PTR_W       (PTR_W),
      .CNT_W       (CNT_W)
    ) u_window_ptr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .advance   (sample_c && (i_upd_stock_id == ID_W'(s))),
      .clear     (i_win_clear && (i_upd_stock_id == ID_W'(s))),
      .wr_ptr    (wr_ptr[s]),
      .count     (count[s])
    );
  end

  // Registered outputs: strobes every cycle, sample fields only on a new sample.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid         <= 1'b0;
      o_crossed       <= 1'b0;
      o_stock_id      <= '0;
      o_best_bid      <= '0;
      o_best_ask      <= '0;
      o_write_address <= '0;
      o_window_full   <= 1'b0;
    end else begin
      o_valid   <= sample_c;
      o_crossed <= crossed_c;
      if (sample_c) begin
        o_stock_id      <= i_upd_stock_id;
        o_best_bid      <= nxt_bid;
        o_best_ask      <= nxt_ask;
        o_write_address <= addr_c;
        o_window_full   <= full_c;
      end
    end
  end

endmodule

// File: tb/tb_mid_price_sampler.sv
// Directed, table-driven bench for mid_price_sampler with default parameters.
module tb_mid_price_sampler;

  logic        clk;
  logic        reset_n;
  logic        upd_valid;
  logic [1:0]  upd_stock_id;
  logic        upd_side;
  logic [31:0] upd_price;
  logic        upd_empty;
  logic        win_clear;
  logic        o_valid;
  logic [1:0]  o_stock_id;
  logic [31:0] o_best_bid;
  logic [31:0] o_best_ask;
  logic [6:0]  o_write_address;
  logic        o_window_full;
  logic        o_crossed;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        v;
    logic [1:0]  id;
    logic        side;
    logic [31:0] price;
    logic        empty;
    logic        clr;
    logic        ev;
    logic        ec;
    logic [1:0]  eid;
    logic [31:0] eb;
    logic [31:0] ea;
    logic [6:0]  eaddr;
    logic        efull;
  } vec_t;

  mid_price_sampler dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_upd_valid     (upd_valid),
    .i_upd_stock_id  (upd_stock_id),
    .i_upd_side      (upd_side),
    .i_upd_price     (upd_price),
    .i_upd_empty     (upd_empty),
    .i_win_clear     (win_clear),
    .o_valid         (o_valid),
    .o_stock_id      (o_stock_id),
    .o_best_bid      (o_best_bid),
    .o_best_ask      (o_best_ask),
    .o_write_address (o_write_address),
    .o_window_full   (o_window_full),
    .o_crossed       (o_crossed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int v, input int id, input int side, input int price,
                              input int empty, input int clr, input int ev, input int ec,
                              input int eid, input int eb, input int ea, input int eaddr,
                              input int efull);
    vec_t t;
    t.v = 1'(v);     t.id = 2'(id);    t.side = 1'(side); t.price = 32'(price);
    t.empty = 1'(empty); t.clr = 1'(clr);
    t.ev = 1'(ev);   t.ec = 1'(ec);    t.eid = 2'(eid);   t.eb = 32'(eb);
    t.ea = 32'(ea);  t.eaddr = 7'(eaddr); t.efull = 1'(efull);
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input vec_t t, input int idx);
    chk("o_valid",         idx, 64'(o_valid),         64'(t.ev));
    chk("o_crossed",       idx, 64'(o_crossed),       64'(t.ec));
    chk("o_stock_id",      idx, 64'(o_stock_id),      64'(t.eid));
    chk("o_best_bid",      idx, 64'(o_best_bid),      64'(t.eb));
    chk("o_best_ask",      idx, 64'(o_best_ask),      64'(t.ea));
    chk("o_write_address", idx, 64'(o_write_address), 64'(t.eaddr));
    chk("o_window_full",   idx, 64'(o_window_full),   64'(t.efull));
  endtask

  // Drive one cycle of inputs, then check the registered result one edge later.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    upd_valid    = t.v;
    upd_stock_id = t.id;
    upd_side     = t.side;
    upd_price    = t.price;
    upd_empty    = t.empty;
    win_clear    = t.clr;
    @(posedge clk);
    #1;
    chk_outputs(t, idx);
  endtask

  vec_t tbl [12];
  vec_t zero_v;

  initial begin
    reset_n = 1'b0; upd_valid = 1'b0; upd_stock_id = '0; upd_side = 1'b0;
    upd_price = '0; upd_empty = 1'b0; win_clear = 1'b0;
    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //           v id s price e c  ev ec id bid  ask addr full
    tbl[0]  = mk(1, 1, 0, 100, 0, 0, 0, 0, 0,   0,   0,  0, 0);
    tbl[1]  = mk(1, 1, 1, 104, 0, 0, 1, 0, 1, 100, 104, 20, 0);
    tbl[2]  = mk(1, 2, 0, 100, 0, 0, 0, 0, 1, 100, 104, 20, 0);
    tbl[3]  = mk(1, 2, 1, 100, 0, 0, 0, 1, 1, 100, 104, 20, 0);
    tbl[4]  = mk(1, 2, 1, 101, 0, 0, 1, 0, 2, 100, 101, 40, 0);
    tbl[5]  = mk(1, 1, 0, 100, 0, 0, 0, 0, 2, 100, 101, 40, 0);
    tbl[6]  = mk(1, 1, 0,   7, 1, 0, 0, 0, 2, 100, 101, 40, 0);
    tbl[7]  = mk(1, 1, 0, 100, 0, 0, 1, 0, 1, 100, 104, 21, 0);
    tbl[8]  = mk(0, 3, 1,   1, 0, 0, 0, 0, 1, 100, 104, 21, 0);
    tbl[9]  = mk(1, 1, 0, 103, 0, 0, 1, 0, 1, 103, 104, 22, 0);
    tbl[10] = mk(1, 1, 0, 104, 0, 0, 0, 1, 1, 103, 104, 22, 0);
    tbl[11] = mk(1, 1, 1, 110, 0, 0, 1, 0, 1, 104, 110, 23, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outputs(zero_v, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic sampling, crossing, duplicates and empty sides
    for (int i = 0; i < 12; i++) apply(tbl[i], 100 + i);

    // Stock 0: 21 back-to-back mid changes wrap the window and saturate fullness
    apply(mk(1, 0, 0, 1000, 0, 0, 0, 0, 1, 104, 110, 23, 0), 200);
    for (int k = 0; k <= 20; k++)
      apply(mk(1, 0, 1, 2000 + k, 0, 0, 1, 0, 0, 1000, 2000 + k, k % 20, (k >= 19) ? 1 : 0), 201 + k);

    // Stock 3: fill window, then clear with a same-cycle update, then clear alone
    apply(mk(1, 3, 0, 10, 0, 0, 0, 0, 0, 1000, 2020, 0, 1), 300);
    for (int k = 0; k < 20; k++)
      apply(mk(1, 3, 1, 20 + k, 0, 0, 1, 0, 3, 10, 20 + k, 60 + k, (k == 19) ? 1 : 0), 301 + k);
    apply(mk(1, 3, 1, 50, 0, 1, 0, 0, 3, 10, 39, 79, 1), 330);
    apply(mk(1, 3, 1, 51, 0, 0, 1, 0, 3, 10, 51, 60, 0), 331);
    apply(mk(0, 3, 0,  0, 0, 1, 0, 0, 3, 10, 51, 60, 0), 332);
    apply(mk(1, 3, 1, 52, 0, 0, 1, 0, 3, 10, 52, 60, 0), 333);

    // Mid-stream reset with an update presented in the reset cycle
    @(negedge clk);
    reset_n = 1'b0;
    upd_valid = 1'b1; upd_stock_id = 2'd0; upd_side = 1'b0; upd_price = 32'd1;
    upd_empty = 1'b0; win_clear = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs(zero_v, 400);
    @(negedge clk);
    reset_n = 1'b1;
    upd_valid = 1'b0;
    apply(mk(1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0), 401);
    apply(mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 5, 9, 0, 0), 402);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 9, 0, 0), 403);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
